// File: rtl/pipe_hazard_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_pkg
//   Shared definitions for the forwarding / load-use hazard unit.
//   - FWD_* : encoding of the EX operand mux select (0 = register file,
//             k = shadow pipeline position k).
//   - shadow_ctl_t : control bits kept per shadow pipeline position.
//   - is_producer : true when a shadow entry will write a register.
// ---------------------------------------------------------------------------
package pipe_hazard_pkg;

  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } shadow_ctl_t;

  function automatic logic is_producer(input shadow_ctl_t e);
    return e.valid & e.regwrite;
  endfunction

endpackage

// File: rtl/fwd_sel_prio.sv
// ---------------------------------------------------------------------------
// fwd_sel_prio
//   Priority encoder for one EX operand. Picks the nearest shadow position
//   (1..NFWD) whose producer writes the operand's source register.
//   Ports:
//     en       in  operand's instruction in EX is valid
//     src      in  source register of this operand
//     producer in  bit k-1 set when shadow position k writes a register
//     rd       in  destination of position k at [(k-1)*AW +: AW]
//     sel      out 0 = register file, k = forward from position k
// ---------------------------------------------------------------------------
module fwd_sel_prio
  import pipe_hazard_pkg::*;
#(
  parameter int AW   = 5,
  parameter int NFWD = 2,
  parameter int SW   = 2
) (
  input  logic              en,
  input  logic [AW-1:0]     src,
  input  logic [NFWD-1:0]   producer,
  input  logic [NFWD*AW-1:0] rd,
  output logic [SW-1:0]     sel
);

  // Scan from the oldest position towards EX/MEM so the nearest match is
  // the last one written and therefore wins. A zero source never matches,
  // which keeps r0 out of forwarding regardless of what producers claim.
  always_comb begin
    sel = SW'(FWD_RF);
    if (en && (src != '0)) begin
      for (int k = NFWD; k >= FWD_EXMEM; k--) begin
        if (producer[k-1] && (rd[(k-1)*AW +: AW] == src)) begin
          sel = SW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding and load-use hazard unit. Tracks in-flight destinations in a
//   shadow pipeline (position 0 = EX .. NFWD), drives one forwarding select
//   per EX operand and stalls ID while a load result is not yet reachable.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     id_valid       ID holds a real instruction
//     id_src         ID source registers, operand i at [i*AW +: AW]
//     id_rd          ID destination register
//     id_regwrite    ID instruction writes id_rd
//     id_memread     ID instruction is a load
//     flush          kill the ID instruction
//     hold           freeze the whole pipeline
//     fwd_sel        EX operand i select at [i*SW +: SW]
//     stall_id       hold PC and IF/ID, insert a bubble into EX
//     stall_cnt      saturating count of stalled, non-held cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 1,
  localparam int SW      = $clog2(NFWD + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [NSRC*AW-1:0]  id_src,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                flush,
  input  logic                hold,
  output logic [NSRC*SW-1:0]  fwd_sel,
  output logic                stall_id,
  output logic [31:0]         stall_cnt
);

  // A load must have reached a forwardable position before the pipeline
  // runs out of places to forward from.
  if (NFWD < LOAD_LAT + 1) begin : g_param_check
    $error("fwd_hazard_unit: NFWD must be >= LOAD_LAT+1");
  end

  shadow_ctl_t           ctl_q [0:NFWD];
  logic [AW-1:0]         rd_q  [0:NFWD];
  logic [NSRC*AW-1:0]    src_q;

  logic                  load_hit;
  logic                  take_id;
  logic [NFWD-1:0]       producer;
  logic [NFWD*AW-1:0]    rd_flat;

  // Load-use detection: a load still inside positions 0..LOAD_LAT-1 cannot
  // be forwarded yet, so any ID consumer of its destination must wait.
  always_comb begin
    load_hit = 1'b0;
    for (int p = 0; p < LOAD_LAT; p++) begin
      for (int j = 0; j < NSRC; j++) begin
        if (ctl_q[p].valid && ctl_q[p].memread && (rd_q[p] != '0) &&
            (rd_q[p] == id_src[j*AW +: AW])) begin
          load_hit = 1'b1;
        end
      end
    end
  end

  assign stall_id = id_valid & ~flush & load_hit;
  assign take_id  = id_valid & ~flush & ~stall_id;

  // Shadow pipeline. hold freezes everything, which also means a flush
  // raised during hold has no effect until hold drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= NFWD; k++) begin
        ctl_q[k] <= '0;
        rd_q[k]  <= '0;
      end
      src_q <= '0;
    end else if (!hold) begin
      for (int k = 1; k <= NFWD; k++) begin
        ctl_q[k] <= ctl_q[k-1];
        rd_q[k]  <= rd_q[k-1];
      end
      if (take_id) begin
        ctl_q[0] <= '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread};
        rd_q[0]  <= id_rd;
        src_q    <= id_src;
      end else begin
        ctl_q[0] <= '0;
        rd_q[0]  <= '0;
        src_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!hold && stall_id && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  for (genvar k = 1; k <= NFWD; k++) begin : g_flat
    assign producer[k-1]          = is_producer(ctl_q[k]);
    assign rd_flat[(k-1)*AW +: AW] = rd_q[k];
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_sel
    fwd_sel_prio #(
      .AW   (AW),
      .NFWD (NFWD),
      .SW   (SW)
    ) u_prio (
      .en       (ctl_q[0].valid),
      .src      (src_q[i*AW +: AW]),
      .producer (producer),
      .rd       (rd_flat),
      .sel      (fwd_sel[i*SW +: SW])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed instruction sequences for the default configuration
//   (AW=5, NSRC=2, NFWD=2, LOAD_LAT=1). Each applied cycle pushes its
//   hand-computed expected outputs into a queue; a monitor pops one entry
//   per cycle and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic        hold;
  logic [3:0]  fwd_sel;
  logic        stall_id;
  logic [31:0] stall_cnt;

  // Expected word: {sel1, sel0, stall_id, stall_cnt}
  logic [36:0] exp_q [$];
  int          n_vec;
  int          n_miss;
  int          n_pushed;

  fwd_hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .hold        (hold),
    .fwd_sel     (fwd_sel),
    .stall_id    (stall_id),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of ID-stage inputs just after the rising edge and queue
  // the outputs expected while they are applied.
  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [4:0] s0, input logic [4:0] s1,
                               input logic [4:0] rd, input logic rw,
                               input logic mr, input logic fl, input logic hd,
                               input logic [1:0] e0, input logic [1:0] e1,
                               input logic es, input logic [31:0] ec);
    @(posedge clk);
    #1;
    reset       = rst;
    id_valid    = v;
    id_src      = {s1, s0};
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
    hold        = hd;
    exp_q.push_back({e1, e0, es, ec});
    n_pushed++;
  endtask

  task automatic checkOutput(input logic [36:0] exp_word);
    logic [36:0] act;
    act = {fwd_sel, stall_id, stall_cnt};
    n_vec++;
    if (act !== exp_word) begin
      n_miss++;
      $display("[TB] FAIL vec%0d: got sel1=%0d sel0=%0d stall=%0b cnt=%0d, want sel1=%0d sel0=%0d stall=%0b cnt=%0d",
               n_vec, act[36:35], act[34:33], act[32], act[31:0],
               exp_word[36:35], exp_word[34:33], exp_word[32], exp_word[31:0]);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, one expectation per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_vec = 0; n_miss = 0; n_pushed = 0;
    reset = 1'b1; id_valid = 1'b0; id_src = '0; id_rd = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);

    //            rst v  s0 s1 rd rw mr fl hd  e0 e1 st cnt
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // in reset
    // add r3 ; add r4,r3 -> EX/MEM forward
    applyStimulus(0, 1, 1, 2, 3, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 4, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    // add r3 ; nop ; sub r5,r2,r3 -> MEM/WB forward on operand 1
    applyStimulus(0, 1, 1, 2, 3, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 1, 2, 3, 5, 1, 0, 0, 0,  0, 0, 0, 0);
    // add r3 ; add r3 ; add r7,r3,r3 -> nearest wins on both operands
    applyStimulus(0, 1, 1, 2, 3, 1, 0, 0, 0,  0, 2, 0, 0);
    applyStimulus(0, 1, 1, 2, 3, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 1, 3, 3, 7, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    // add r0 ; add r8,r0,r0 ; lw r0 ; use r0 -> no forward, no stall
    applyStimulus(0, 1, 1, 2, 0, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 8, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 9, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // lw r2 ; add r6,r2,r4 -> one bubble, then MEM/WB forward
    applyStimulus(0, 1, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 1, 2, 4, 6, 1, 0, 0, 0,  0, 0, 1, 0);
    applyStimulus(0, 1, 2, 4, 6, 1, 0, 0, 0,  0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1);
    // lw r2 ; dependent flushed -> no stall, bubble in EX
    applyStimulus(0, 1, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 1);
    applyStimulus(0, 1, 2, 0, 6, 1, 0, 1, 0,  0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    // lw r2 ; dependent with hold for 3 cycles mid-stall
    applyStimulus(0, 1, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 1);
    applyStimulus(0, 1, 2, 0, 6, 1, 0, 0, 1,  0, 0, 1, 1);
    applyStimulus(0, 1, 2, 0, 6, 1, 0, 0, 1,  0, 0, 1, 1);
    applyStimulus(0, 1, 2, 0, 6, 1, 0, 0, 1,  0, 0, 1, 1);
    applyStimulus(0, 1, 2, 0, 6, 1, 0, 0, 0,  0, 0, 1, 1);
    applyStimulus(0, 1, 2, 0, 6, 1, 0, 0, 0,  0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 2);
    // lw r2 ; reset while stalled -> everything dropped
    applyStimulus(0, 1, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 2);
    applyStimulus(1, 1, 2, 0, 6, 1, 0, 0, 0,  0, 0, 1, 2);
    applyStimulus(0, 1, 2, 0, 6, 1, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() > 0 || n_vec != n_pushed) begin
      n_miss++;
      $display("[TB] FAIL drain: checked %0d, want %0d", n_vec, n_pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
